inst_prefetch_queue: RTL and testbench
======================================

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the queue entries; legal values are powers of two from 2 to 16.
REQ-002 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the first fetch address.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-005 Port imem_req SHALL be an output, 1 bit wide, and pulse for one cycle per instruction-memory request.
REQ-006 Port imem_addr SHALL be an output, 32 bits wide, giving the word address of the current request.
REQ-007 Port imem_valid SHALL be an input, 1 bit wide, and mark the cycle in which the memory response is present.
REQ-008 Port imem_inst SHALL be an input, 32 bits wide, carrying the response instruction word.
REQ-009 Port inst_valid SHALL be an output, 1 bit wide, asserted when the queue head holds an instruction.
REQ-010 Port inst SHALL be an output, 32 bits wide, carrying the head instruction.
REQ-011 Port inst_pc SHALL be an output, 32 bits wide, carrying the head instruction's address.
REQ-012 Port inst_ready SHALL be an input, 1 bit wide, driven low by the core while it stalls (cache_done low).
REQ-013 Ports redirect (input, 1 bit) and redirect_addr (input, 32 bits) SHALL carry a branch/jump target from the core.
REQ-014 Port halted SHALL be an input, 1 bit wide; while high, no new request is issued.

Function
REQ-015 A pop SHALL occur on a rising edge where inst_valid and inst_ready are both high; inst, inst_pc and inst_valid then present the next entry.
REQ-016 FSM states SHALL be IDLE (nothing outstanding), WAIT (one request outstanding) and DRAIN (one discarded request outstanding).
REQ-017 In IDLE with count < DEPTH, halted low and redirect low, the block SHALL drive imem_req high for one cycle with imem_addr = fetch_pc, then enter WAIT.
REQ-018 At most one request SHALL be outstanding; the queue slot is reserved at issue, so a push never overflows.
REQ-019 In WAIT, imem_valid SHALL push {fetch_pc, imem_inst}; fetch_pc becomes fetch_pc+4 modulo 2^32; the state returns to IDLE.
REQ-020 A pushed entry SHALL become visible on inst_valid in the cycle after imem_valid, even when the queue was empty.
REQ-021 The block SHALL support a push and a pop on the same edge; count is then unchanged.
REQ-022 redirect SHALL flush all entries and set fetch_pc to {redirect_addr[31:2],2'b00} on the same edge; inst_valid is low in the next cycle.
REQ-023 If redirect arrives in WAIT without imem_valid, the state SHALL become DRAIN; the next imem_valid is discarded and the state goes to IDLE.
REQ-024 If redirect and imem_valid coincide in WAIT, the response SHALL be discarded and the state goes to IDLE.
REQ-025 Redirect SHALL have priority over a simultaneous pop; the pop is ignored.
REQ-026 imem_valid in IDLE SHALL be ignored.
REQ-027 halted SHALL not cancel an outstanding request; its response is still pushed, and queued entries stay poppable.

Reset
REQ-028 On reset, the block SHALL set imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, count=0, fetch_pc=RESET_PC and the state to IDLE.
REQ-029 Reset during WAIT or DRAIN SHALL drop the outstanding request; the instruction memory is reset together with this block.
REQ-030 The first imem_req SHALL be asserted in the first cycle after reset deasserts.

Structure
REQ-031 The package mips_pkg SHALL hold the FSM state enum, the entry struct {pc[31:0], inst[31:0]} and the constant PFQ_DEPTH_DEFAULT = 4.
REQ-032 Storage SHALL be a sub-module pfq_fifo: a synchronous FIFO with push, pop, flush, count and head outputs; the FSM and fetch_pc reside in the top level.

Verification
REQ-033 Release reset with imem_valid returning 2 cycles after each req: requests go to 0x0, 0x4, 0x8, ...; inst_pc=0x0 is valid 3 cycles after the first req.
REQ-034 Hold inst_ready low with DEPTH=4: exactly 4 requests issue, imem_req stays low, and the queue holds 0x0..0xC; one pop then allows the request to 0x10.
REQ-035 Redirect to 0x103 while in WAIT: the late response is discarded, the next request goes to 0x100, and the first popped inst_pc is 0x100.
REQ-036 Redirect coincides with imem_valid and a pop: the queue is empty next cycle, the next request goes to the target, and no stale entry is ever popped.
REQ-037 Redirect to 0xFFFF_FFFC: the fetch sequence is 0xFFFF_FFFC then 0x0000_0000.
REQ-038 Assert halted with 2 entries queued and one outstanding: 3 entries become poppable and no further imem_req occurs.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: prefetch-queue FSM states, queue entry {pc, inst} and default queue depth
package mips_pkg;
  localparam int PFQ_DEPTH_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} pfq_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfq_entry_t;
endpackage

// File: rtl/pfq_fifo.sv
// pfq_fifo: sync FIFO of fetched entries; in: clk, reset, push, push_data, pop, flush; out: count, head_valid, head (zero when empty)
import mips_pkg::*;
module pfq_fifo #(
  parameter int DEPTH = PFQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  pfq_entry_t               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output pfq_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  pfq_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= push_data;
  assign head_valid = count != '0;
  assign head = head_valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: single-outstanding instruction prefetcher; imem_req/imem_addr out, imem_valid/imem_inst in, inst_valid/inst/inst_pc head out, inst_ready/redirect/redirect_addr/halted in
import mips_pkg::*;
module inst_prefetch_queue #(
  parameter int          DEPTH    = PFQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_inst,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  pfq_state_e state, state_next;
  logic [31:0] fetch_pc;
  logic [CW-1:0] count;
  logic push, pop;
  pfq_entry_t push_data, head;
  assign push_data = {fetch_pc, imem_inst};
  assign pop = inst_valid && inst_ready && !redirect;
  pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .flush(redirect),
    .count(count),
    .head_valid(inst_valid),
    .head(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    imem_req = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: begin
        imem_req = !reset && count < CW'(DEPTH) && !halted && !redirect;
        state_next = imem_req ? WAIT : IDLE;
      end
      WAIT: begin
        push = imem_valid && !redirect;
        state_next = imem_valid ? IDLE : redirect ? DRAIN : WAIT;
      end
      DRAIN: state_next = imem_valid ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_addr & ~32'd3;
    else if (push) fetch_pc <= fetch_pc + 32'd4;
  assign imem_addr = fetch_pc;
  assign inst = head.inst;
  assign inst_pc = head.pc;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: table, directed and random checks of inst_prefetch_queue against a queue-based model
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;
  logic clk = 0, reset = 0, imem_req, imem_valid = 0, inst_valid, inst_ready = 0, redirect = 0, halted = 0;
  logic [31:0] imem_addr, imem_inst = '0, inst, inst_pc, redirect_addr = '0;
  int checks = 0, errors = 0;
  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_inst(imem_inst), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_addr(redirect_addr), .halted(halted)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {bit ready; bit req; logic [31:0] addr; bit valid; logic [31:0] pc;} vec_t;
  ent_t m_q[$];
  logic [31:0] m_fpc = '0;
  bit m_pend = 0, m_drop = 0, spur = 0;
  int rdue = 0, lat = 2;
  logic [31:0] raddr = '0;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit m_req();
    return !reset && !m_pend && m_q.size() < DEPTH && !halted && !redirect;
  endfunction
  task automatic m_step();
    bit req, popv;
    if (reset) return;
    req = m_req();
    popv = m_q.size() != 0 && inst_ready;
    if (redirect) begin
      m_q.delete();
      m_fpc = {redirect_addr[31:2], 2'b00};
      if (m_pend) begin
        if (imem_valid) begin m_pend = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (popv) void'(m_q.pop_front());
      if (m_pend && imem_valid) begin
        if (!m_drop) begin
          m_q.push_back('{pc: m_fpc, inst: imem_inst});
          m_fpc = m_fpc + 32'd4;
        end
        m_pend = 0;
        m_drop = 0;
      end
      if (req) m_pend = 1;
    end
  endtask
  task automatic half_a();
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    chk("imem_addr", imem_addr, m_fpc);
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    chk("inst", inst, m_q.size() != 0 ? m_q[0].inst : 32'h0);
    chk("inst_pc", inst_pc, m_q.size() != 0 ? m_q[0].pc : 32'h0);
    if (imem_req) begin rdue = lat; raddr = imem_addr; end
    m_step();
  endtask
  task automatic half_b();
    @(posedge clk);
    #1;
    if (rdue > 0) begin
      rdue--;
      imem_valid = rdue == 0;
      imem_inst = raddr ^ MAGIC;
    end else begin
      imem_valid = spur && $urandom_range(0, 7) == 0;
      imem_inst = 32'h0BAD_0BAD;
    end
  endtask
  task automatic cycle();
    half_a();
    half_b();
  endtask
  task automatic apply_reset();
    reset = 1; imem_valid = 0; inst_ready = 0; halted = 0; redirect = 0; rdue = 0; spur = 0;
    m_q.delete(); m_fpc = 32'h0; m_pend = 0; m_drop = 0;
    cycle();
    reset = 0;
  endtask
  task automatic run_to_req(input string name, input logic [31:0] exp);
    bit got;
    logic [31:0] a;
    got = 0;
    a = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      half_a();
      if (imem_req) begin got = 1; a = imem_addr; end
      half_b();
    end
    chk({name, "_seen"}, 32'(got), 32'd1);
    chk(name, a, exp);
  endtask
  task automatic run_to_inst(input string name, input logic [31:0] exp);
    bit got;
    logic [31:0] a;
    got = 0;
    a = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      half_a();
      if (inst_valid) begin got = 1; a = inst_pc; end
      half_b();
    end
    chk({name, "_seen"}, 32'(got), 32'd1);
    chk(name, a, exp);
  endtask
  initial begin
    int seen, reqs, pops;
    tbl[0]  = '{0, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 0, 32'h00, 0, 32'h0};
    tbl[2]  = '{0, 0, 32'h00, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'h04, 1, 32'h0};
    tbl[4]  = '{0, 0, 32'h04, 1, 32'h0};
    tbl[5]  = '{0, 0, 32'h04, 1, 32'h0};
    tbl[6]  = '{0, 1, 32'h08, 1, 32'h0};
    tbl[7]  = '{0, 0, 32'h08, 1, 32'h0};
    tbl[8]  = '{0, 0, 32'h08, 1, 32'h0};
    tbl[9]  = '{0, 1, 32'h0C, 1, 32'h0};
    tbl[10] = '{0, 0, 32'h0C, 1, 32'h0};
    tbl[11] = '{0, 0, 32'h0C, 1, 32'h0};
    tbl[12] = '{0, 0, 32'h10, 1, 32'h0};
    tbl[13] = '{1, 0, 32'h10, 1, 32'h0};
    tbl[14] = '{0, 1, 32'h10, 1, 32'h4};
    tbl[15] = '{0, 0, 32'h10, 1, 32'h4};
    #1;
    apply_reset();
    lat = 2;
    for (int i = 0; i < 16; i++) begin
      inst_ready = tbl[i].ready;
      half_a();
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].valid));
      chk("tbl_pc", inst_pc, tbl[i].valid ? tbl[i].pc : 32'h0);
      chk("tbl_inst", inst, tbl[i].valid ? tbl[i].pc ^ MAGIC : 32'h0);
      half_b();
    end
    apply_reset();
    lat = 3;
    cycle();
    redirect = 1;
    redirect_addr = 32'h103;
    cycle();
    redirect = 0;
    run_to_req("drain_req", 32'h100);
    inst_ready = 1;
    run_to_inst("drain_pop", 32'h100);
    apply_reset();
    lat = 2;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (imem_valid) seen++;
      if (seen == 2) break;
      cycle();
    end
    chk("coinc_resp_seen", seen, 2);
    redirect = 1;
    redirect_addr = 32'h200;
    inst_ready = 1;
    cycle();
    redirect = 0;
    inst_ready = 0;
    half_a();
    chk("coinc_empty", 32'(inst_valid), 32'd0);
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", imem_addr, 32'h200);
    half_b();
    inst_ready = 1;
    run_to_inst("coinc_pop", 32'h200);
    apply_reset();
    inst_ready = 1;
    redirect = 1;
    redirect_addr = 32'hFFFF_FFFC;
    cycle();
    redirect = 0;
    lat = 1;
    run_to_req("wrap_hi", 32'hFFFF_FFFC);
    run_to_req("wrap_lo", 32'h0000_0000);
    apply_reset();
    lat = 2;
    for (int n = 0; n < 7; n++) cycle();
    halted = 1;
    reqs = 0;
    for (int n = 0; n < 12; n++) begin
      half_a();
      if (imem_req) reqs++;
      half_b();
    end
    chk("halt_no_req", reqs, 0);
    inst_ready = 1;
    pops = 0;
    for (int n = 0; n < 10; n++) begin
      half_a();
      if (inst_valid && inst_ready) pops++;
      if (imem_req) reqs++;
      half_b();
    end
    chk("halt_pops", pops, 3);
    chk("halt_no_req2", reqs, 0);
    halted = 0;
    spur = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        spur = 1;
      end
      inst_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 31) == 0) halted = !halted;
      redirect = $urandom_range(0, 19) == 0;
      redirect_addr = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      lat = $urandom_range(1, 4);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
